// File: rtl/otter_intr_ctrl.sv
// OTTER interrupt controller: synchronised edge-latched sources, fixed-priority arbitration, CPU handshake.
// Optional CAUSE output is enabled by defining OTTER_INTR_CAUSE_EN.
module otter_intr_ctrl #(
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NUM_SRC-1:0] INTR_SRC,
    input  logic               CSR_MIE,
    input  logic               MASK_WE,
    input  logic [NUM_SRC-1:0] MASK_WD,
    input  logic               INT_ACK,
    input  logic               MRET,
    output logic               INTR_REQ,
    output logic               INT_TAKEN,
    output logic [NUM_SRC-1:0] PENDING,
    output logic [NUM_SRC-1:0] MASK
`ifdef OTTER_INTR_CAUSE_EN
    ,
    output logic [3:0]         CAUSE
`endif
);

    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        TAKE   = 2'd2,
        ACTIVE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] edge_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] mask_q;
    logic [IDX_W-1:0]   winner_q;
    logic               intr_req_q;
    logic               int_taken_q;

    logic [NUM_SRC-1:0] rise_c;
    logic [NUM_SRC-1:0] eligible_c;
    logic [NUM_SRC-1:0] win_onehot_c;
    logic [NUM_SRC-1:0] clr_c;
    logic [IDX_W-1:0]   win_idx_c;
    logic               win_en_c;
    logic               latch_win_c;

    // Synchroniser chain plus one-flop edge detector per source
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            edge_q <= '0;
        end else begin
            sync_q[0] <= INTR_SRC;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_c     = sync_q[SYNC_STAGES-1] & ~edge_q;
    assign eligible_c = pending_q & mask_q;

    // Lowest eligible index wins; the frozen winner is decoded back to one-hot
    always_comb begin
        win_idx_c    = '0;
        win_onehot_c = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (eligible_c[i]) begin
                win_idx_c = IDX_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            win_onehot_c[i] = (winner_q == IDX_W'(i));
        end
    end

    assign win_en_c = |(mask_q & win_onehot_c);

    // Next-state logic; a dropped enable in REQ takes precedence over INT_ACK
    always_comb begin
        state_d     = state_q;
        latch_win_c = 1'b0;
        clr_c       = '0;
        case (state_q)
            IDLE: begin
                if ((|eligible_c) && CSR_MIE) begin
                    state_d     = REQ;
                    latch_win_c = 1'b1;
                end
            end
            REQ: begin
                if (!CSR_MIE || !win_en_c) begin
                    state_d = IDLE;
                end else if (INT_ACK) begin
                    state_d = TAKE;
                end
            end
            TAKE: begin
                state_d = ACTIVE;
                clr_c   = win_onehot_c;
            end
            ACTIVE: begin
                if (MRET) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            mask_q      <= '0;
            winner_q    <= '0;
            intr_req_q  <= 1'b0;
            int_taken_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            intr_req_q  <= (state_d == REQ);
            int_taken_q <= (state_d == TAKE);
            // A new edge in the same cycle as the clear keeps the bit pending
            pending_q   <= (pending_q & ~clr_c) | rise_c;
            if (latch_win_c) begin
                winner_q <= win_idx_c;
            end
            if (MASK_WE) begin
                mask_q <= MASK_WD;
            end
        end
    end

`ifdef OTTER_INTR_CAUSE_EN
    logic [3:0] cause_q;

    // Loaded on entry to TAKE so it is valid alongside INT_TAKEN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cause_q <= '0;
        end else if (state_d == TAKE) begin
            cause_q <= 4'(winner_q);
        end
    end

    assign CAUSE = cause_q;
`endif

    assign INTR_REQ  = intr_req_q;
    assign INT_TAKEN = int_taken_q;
    assign PENDING   = pending_q;
    assign MASK      = mask_q;

endmodule
